// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// client ID type and the helpers that insert/strip the client ID carried
// in the top bits of the memory tag.
`ifndef MIFAddrBits
`define MIFAddrBits 32
`endif
`ifndef MIFTagBits
`define MIFTagBits 8
`endif
`ifndef MIFDataBits
`define MIFDataBits 32
`endif

package mem_arb_pkg;

    localparam int ARB_N_CLIENTS = 2;
    localparam int ARB_IDW       = $clog2(ARB_N_CLIENTS);
    localparam int TAG_W         = `MIFTagBits;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    typedef logic [ARB_IDW-1:0] mem_arb_id_t;

    // Mask covering the client-visible part of the tag.
    function automatic logic [TAG_W-1:0] tag_low_mask(input int idw);
        return {TAG_W{1'b1}} >> idw;
    endfunction

    // Replace the top idw bits of a client tag with the client ID.
    function automatic logic [TAG_W-1:0] tag_insert_id(input logic [TAG_W-1:0] tag,
                                                       input logic [TAG_W-1:0] id,
                                                       input int idw);
        return (tag & tag_low_mask(idw)) | (id << (TAG_W - idw));
    endfunction

    // Clear the ID field before the tag is handed back to a client.
    function automatic logic [TAG_W-1:0] tag_strip_id(input logic [TAG_W-1:0] tag,
                                                      input int idw);
        return tag & tag_low_mask(idw);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin request arbiter: the first asserted request at or above ptr
// (wrapping) wins. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Walk the offsets from the far end back to ptr so the nearest request wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = IW'(idx);
            end
        end
        gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter: shares one memory command/data/response port among
// N_CLIENTS requesters. Commands are arbitrated round-robin; a granted write
// locks the data channel to its owner for DATA_BEATS beats; responses are
// routed back by the client ID held in the top tag bits.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (client 0
// highest) instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CLIENTS  = 2,
    parameter int DATA_BEATS = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [N_CLIENTS-1:0]             c_cmd_valid,
    output logic [N_CLIENTS-1:0]             c_cmd_ready,
    input  logic [N_CLIENTS*`MIFAddrBits-1:0] c_cmd_addr,
    input  logic [N_CLIENTS*`MIFTagBits-1:0]  c_cmd_tag,
    input  logic [N_CLIENTS-1:0]             c_cmd_rw,
    input  logic [N_CLIENTS-1:0]             c_data_valid,
    output logic [N_CLIENTS-1:0]             c_data_ready,
    input  logic [N_CLIENTS*`MIFDataBits-1:0] c_data,
    output logic [N_CLIENTS-1:0]             c_resp_valid,
    output logic [`MIFDataBits-1:0]          c_resp_data,
    output logic [`MIFTagBits-1:0]           c_resp_tag,
    output logic                             mem_cmd_valid,
    input  logic                             mem_cmd_ready,
    output logic [`MIFAddrBits-1:0]          mem_cmd_addr,
    output logic [`MIFTagBits-1:0]           mem_cmd_tag,
    output logic                             mem_cmd_rw,
    output logic                             mem_data_valid,
    input  logic                             mem_data_ready,
    output logic [`MIFDataBits-1:0]          mem_data,
    input  logic                             mem_resp_valid,
    input  logic [`MIFDataBits-1:0]          mem_resp_data,
    input  logic [`MIFTagBits-1:0]           mem_resp_tag
);

    localparam int IDW = $clog2(N_CLIENTS);
    localparam int AW  = `MIFAddrBits;
    localparam int TW  = `MIFTagBits;
    localparam int DW  = `MIFDataBits;
    localparam int BW  = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [IDW-1:0]       arb_ptr;
    logic [IDW-1:0]       owner;
    logic [BW-1:0]        beat_cnt;
    logic [N_CLIENTS-1:0] grant_oh;
    logic [IDW-1:0]       grant;
    logic                 cmd_any;
    logic                 cmd_hs;
    logic                 data_hs;
    logic                 last_beat;
    logic                 grant_rw;
    logic [IDW-1:0]       resp_id;

    rr_arbiter #(
        .N (N_CLIENTS)
    ) u_rr (
        .req     (c_cmd_valid),
        .ptr     (arb_ptr),
        .gnt     (grant_oh),
        .gnt_idx (grant),
        .gnt_any (cmd_any)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: always search from client 0.
    assign arb_ptr = '0;
`else
    logic [IDW-1:0] rr_ptr;

    // Advance the round-robin pointer past each granted client.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (cmd_hs) begin
            rr_ptr <= (int'(grant) == N_CLIENTS - 1) ? '0 : grant + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    assign grant_rw  = c_cmd_rw[grant];
    assign cmd_hs    = (state == IDLE) && cmd_any && mem_cmd_ready;
    assign data_hs   = (state == WDATA) && c_data_valid[owner] && mem_data_ready;
    assign last_beat = (beat_cnt == BW'(DATA_BEATS - 1));
    assign resp_id   = mem_resp_tag[TW-1 -: IDW];

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter WDATA on a write command, leave after the last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs && grant_rw) state_nxt = WDATA;
            WDATA:   if (data_hs && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the write owner and count its data beats.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner    <= '0;
            beat_cnt <= '0;
        end else if (cmd_hs && grant_rw) begin
            owner    <= grant;
            beat_cnt <= '0;
        end else if (data_hs) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // Handshake outputs; everything valid/ready is held low during reset.
    always_comb begin
        mem_cmd_valid  = 1'b0;
        c_cmd_ready    = '0;
        mem_data_valid = 1'b0;
        c_data_ready   = '0;
        c_resp_valid   = '0;
        if (rstn) begin
            case (state)
                IDLE: begin
                    mem_cmd_valid = cmd_any;
                    c_cmd_ready   = mem_cmd_ready ? grant_oh : '0;
                end
                WDATA: begin
                    mem_data_valid      = c_data_valid[owner];
                    c_data_ready[owner] = mem_data_ready;
                end
                default: ;
            endcase
            for (int i = 0; i < N_CLIENTS; i++) begin
                c_resp_valid[i] = mem_resp_valid && (int'(resp_id) == i);
            end
        end
    end

    // Payload muxes: command from the current grant, data from the write owner.
    always_comb begin
        mem_cmd_addr = c_cmd_addr[grant*AW +: AW];
        mem_cmd_rw   = grant_rw;
        mem_cmd_tag  = tag_insert_id(c_cmd_tag[grant*TW +: TW], TW'(grant), IDW);
        mem_data     = c_data[owner*DW +: DW];
        c_resp_data  = mem_resp_data;
        c_resp_tag   = tag_strip_id(mem_resp_tag, IDW);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (N_CLIENTS=2, DATA_BEATS=4).
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int AW = `MIFAddrBits;
    localparam int TW = `MIFTagBits;
    localparam int DW = `MIFDataBits;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    c_cmd_valid;
    logic [N-1:0]    c_cmd_ready;
    logic [N*AW-1:0] c_cmd_addr;
    logic [N*TW-1:0] c_cmd_tag;
    logic [N-1:0]    c_cmd_rw;
    logic [N-1:0]    c_data_valid;
    logic [N-1:0]    c_data_ready;
    logic [N*DW-1:0] c_data;
    logic [N-1:0]    c_resp_valid;
    logic [DW-1:0]   c_resp_data;
    logic [TW-1:0]   c_resp_tag;
    logic            mem_cmd_valid;
    logic            mem_cmd_ready;
    logic [AW-1:0]   mem_cmd_addr;
    logic [TW-1:0]   mem_cmd_tag;
    logic            mem_cmd_rw;
    logic            mem_data_valid;
    logic            mem_data_ready;
    logic [DW-1:0]   mem_data;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_resp_data;
    logic [TW-1:0]   mem_resp_tag;

    always #5 clk = ~clk;

    mem_arbiter #(.N_CLIENTS(N), .DATA_BEATS(DB)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .c_cmd_valid    (c_cmd_valid),
        .c_cmd_ready    (c_cmd_ready),
        .c_cmd_addr     (c_cmd_addr),
        .c_cmd_tag      (c_cmd_tag),
        .c_cmd_rw       (c_cmd_rw),
        .c_data_valid   (c_data_valid),
        .c_data_ready   (c_data_ready),
        .c_data         (c_data),
        .c_resp_valid   (c_resp_valid),
        .c_resp_data    (c_resp_data),
        .c_resp_tag     (c_resp_tag),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_cmd_tag    (mem_cmd_tag),
        .mem_cmd_rw     (mem_cmd_rw),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_tag   (mem_resp_tag)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW+TW:0]      cmd_q[$];
    logic [DW-1:0]       data_q[$];
    logic [N+TW+DW-1:0]  resp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor: pop and compare on every memory-side handshake and response.
    logic [63:0] mon_exp;
    always @(negedge clk) begin
        if (mem_cmd_valid && mem_cmd_ready) begin
            if (cmd_q.size() == 0) unexpected("mem_cmd", {mem_cmd_addr, mem_cmd_tag, mem_cmd_rw});
            else begin
                mon_exp = 64'(cmd_q.pop_front());
                chk("mem_cmd", {mem_cmd_addr, mem_cmd_tag, mem_cmd_rw}, mon_exp);
            end
        end
        if (mem_data_valid && mem_data_ready) begin
            if (data_q.size() == 0) unexpected("mem_data", mem_data);
            else begin
                mon_exp = 64'(data_q.pop_front());
                chk("mem_data", mem_data, mon_exp);
            end
        end
        if (c_resp_valid != '0) begin
            if (resp_q.size() == 0) unexpected("resp", {c_resp_valid, c_resp_tag, c_resp_data});
            else begin
                mon_exp = 64'(resp_q.pop_front());
                chk("resp", {c_resp_valid, c_resp_tag, c_resp_data}, mon_exp);
            end
        end
    end

    task automatic set_cmd(input int c, input logic v, input logic rw,
                           input logic [AW-1:0] a, input logic [TW-1:0] t);
        c_cmd_valid[c]         = v;
        c_cmd_rw[c]            = rw;
        c_cmd_addr[c*AW +: AW] = a;
        c_cmd_tag[c*TW +: TW]  = t;
    endtask

    // Hold a command until granted; stall counts cycles seen without ready.
    task automatic wait_cmd_ready(input int c, output int stall);
        int guard;
        stall = 0;
        guard = 0;
        while (guard < 50) begin
            @(negedge clk);
            if (c_cmd_ready[c]) break;
            stall++;
            guard++;
        end
        if (guard >= 50) unexpected("cmd_ready_timeout", 64'(c));
        @(posedge clk);
        #1;
        c_cmd_valid[c] = 1'b0;
    endtask

    // Client data BFM: advance to the next beat only after a handshake.
    task automatic send_burst(input int c, input int n, input logic [DW-1:0] base, input bit toggle);
        int b;
        int guard;
        logic hs;
        b = 0;
        guard = 0;
        mem_data_ready = 1'b1;
        c_data_valid[c] = 1'b1;
        c_data[c*DW +: DW] = base;
        while (b < n && guard < 100) begin
            @(negedge clk);
            hs = c_data_ready[c];
            @(posedge clk);
            #1;
            if (hs) begin
                b++;
                c_data[c*DW +: DW] = base + DW'(b);
            end
            if (toggle) mem_data_ready = ~mem_data_ready;
            guard++;
        end
        if (guard >= 100) unexpected("data_timeout", 64'(b));
        c_data_valid[c] = 1'b0;
        mem_data_ready  = 1'b1;
    endtask

    task automatic push_cmd(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic rw);
        cmd_q.push_back({a, t, rw});
    endtask

    task automatic push_data(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) data_q.push_back(base + DW'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, st;
        rstn           = 1'b0;
        c_cmd_valid    = '0;
        c_cmd_addr     = '0;
        c_cmd_tag      = '0;
        c_cmd_rw       = '0;
        c_data_valid   = '0;
        c_data         = '0;
        mem_cmd_ready  = 1'b1;
        mem_data_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_tag   = '0;

        // Reset with everything asserted: all valid/ready outputs stay low.
        set_cmd(0, 1'b1, 1'b0, 32'h100, 8'h05);
        set_cmd(1, 1'b1, 1'b0, 32'h200, 8'h05);
        c_data_valid   = 2'b11;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 8'h83;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {c_cmd_ready, c_data_ready, c_resp_valid, mem_cmd_valid, mem_data_valid}, 64'h0);
        end
        @(posedge clk);
        #1;
        rstn           = 1'b1;
        c_data_valid   = '0;
        mem_resp_valid = 1'b0;

        // Round-robin reads: 0,1,0,1,0 with the client ID in the tag MSB.
        push_cmd(32'h100, 8'h05, 1'b0);
        push_cmd(32'h200, 8'h85, 1'b0);
        push_cmd(32'h100, 8'h05, 1'b0);
        push_cmd(32'h200, 8'h85, 1'b0);
        push_cmd(32'h100, 8'h05, 1'b0);
        @(negedge clk);
        chk("first_grant", c_cmd_ready, 64'h1);
        repeat (5) @(posedge clk);
        #1;
        c_cmd_valid = '0;

        // Write lock: client 1 writes while client 0 waits with a read.
        set_cmd(1, 1'b1, 1'b1, 32'h300, 8'h07);
        set_cmd(0, 1'b1, 1'b0, 32'h400, 8'h02);
        push_cmd(32'h300, 8'h87, 1'b1);
        push_data(32'hD0, 4);
        push_cmd(32'h400, 8'h02, 1'b0);
        fork
            begin
                wait_cmd_ready(0, s0);
                chk("write_lock_stall", 64'(s0), 64'd5);
            end
            begin
                wait_cmd_ready(1, s1);
                send_burst(1, 4, 32'hD0, 1'b0);
            end
        join

        // Data backpressure plus a response delivered mid-burst.
        set_cmd(0, 1'b1, 1'b1, 32'h500, 8'h11);
        push_cmd(32'h500, 8'h11, 1'b1);
        push_data(32'hE0, 4);
        push_cmd(32'h600, 8'h89, 1'b0);
        resp_q.push_back({2'b10, 8'h03, 32'hAAAA5555});
        wait_cmd_ready(0, s0);
        fork
            send_burst(0, 4, 32'hE0, 1'b1);
            begin
                set_cmd(1, 1'b1, 1'b0, 32'h600, 8'h09);
                wait_cmd_ready(1, st);
                chk("backpressure_stall", 64'(st), 64'd7);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                mem_resp_valid = 1'b1;
                mem_resp_tag   = 8'h83;
                mem_resp_data  = 32'hAAAA5555;
                @(posedge clk);
                #1;
                mem_resp_valid = 1'b0;
            end
        join

        // Response to client 0 while idle.
        resp_q.push_back({2'b01, 8'h05, 32'h12345678});
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 8'h05;
        mem_resp_data  = 32'h12345678;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;

        // Reset mid-write: two beats then abandon the burst.
        set_cmd(0, 1'b1, 1'b1, 32'h700, 8'h01);
        push_cmd(32'h700, 8'h01, 1'b1);
        push_data(32'hF0, 2);
        wait_cmd_ready(0, s0);
        send_burst(0, 2, 32'hF0, 1'b0);
        rstn            = 1'b0;
        c_data_valid[0] = 1'b1;
        @(negedge clk);
        chk("midwrite_reset_outputs", {c_cmd_ready, c_data_ready, c_resp_valid, mem_cmd_valid, mem_data_valid}, 64'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_holds_data", {mem_data_valid, c_data_ready}, 64'h0);
        @(posedge clk);
        #1;

        // Fresh write needs all four beats before client 0 gets in.
        set_cmd(1, 1'b1, 1'b1, 32'h800, 8'h0A);
        push_cmd(32'h800, 8'h8A, 1'b1);
        push_data(32'hC0, 4);
        push_cmd(32'h900, 8'h04, 1'b0);
        wait_cmd_ready(1, s1);
        fork
            send_burst(1, 4, 32'hC0, 1'b0);
            begin
                set_cmd(0, 1'b1, 1'b0, 32'h900, 8'h04);
                wait_cmd_ready(0, st);
                chk("post_reset_write_stall", 64'(st), 64'd4);
            end
        join
        c_data_valid = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
        chk("data_queue_empty", 64'(data_q.size()), 64'd0);
        chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
